sub_8_bit_serial: RTL and testbench

Bit-serial 8-bit subtractor computing `diff = a - b - borrowIn`, one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart of the parallel 8-bit adder in the arithmetic datapath. It trades latency for area and exposes a start/done handshake so a sequencing FSM can issue operations and collect results.

---
 rtl/sub_8_bit_serial_if.sv | 31 +++
 rtl/sub_8_bit_serial.sv | 146 ++++++++++++++
 tb/tb_sub_8_bit_serial.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sub_8_bit_serial_if.sv
// ============================================================================
//  Module      : sub_8_bit_serial_if
//  Description : Start/done request bus for the bit-serial 8-bit subtractor.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sub_8_bit_serial_if;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       borrowIn;
    logic       ready;
    logic       done;
    logic [7:0] diff;
    logic       borrowOut;
    logic       overflow;

    // Master issues operations and collects results; slave is the subtractor.
    modport master (
        output start, a, b, borrowIn,
        input  ready, done, diff, borrowOut, overflow
    );

    modport slave (
        input  start, a, b, borrowIn,
        output ready, done, diff, borrowOut, overflow
    );
endinterface

`default_nettype wire

// File: rtl/sub_8_bit_serial.sv
// ============================================================================
//  Module      : sub_8_bit_serial
//  Description : Bit-serial 8-bit subtractor, diff = a - b - borrowIn, LSB first.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sub_8_bit_serial (
    input  wire                  clk,
    input  wire                  rst,
    sub_8_bit_serial_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] c_LAST_BIT = 3'd7;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_a_sr;
    logic [7:0] r_b_sr;
    logic [7:0] r_res_sr;
    logic       r_bff;
    logic [2:0] r_cnt;
    logic       r_a_msb;
    logic       r_b_msb;

    logic [7:0] r_diff;
    logic       r_borrow_out;
    logic       r_overflow;

    logic       w_accept;
    logic       w_shift;
    logic       w_last;
    logic       w_a0;
    logic       w_b0;
    logic       w_d;
    logic       w_bff_nxt;
    logic [7:0] w_res_nxt;

    // ------------------------------------------------------------------
    // Full-subtractor cell
    // ------------------------------------------------------------------
    always_comb begin
        w_a0      = r_a_sr[0];
        w_b0      = r_b_sr[0];
        w_d       = w_a0 ^ w_b0 ^ r_bff;
        w_bff_nxt = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_bff);
        w_res_nxt = {w_d, r_res_sr[7:1]};
    end

    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_shift  = (r_state == S_SHIFT);
    assign w_last   = w_shift && (r_cnt == c_LAST_BIT);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == c_LAST_BIT) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand / result shift path
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr   <= 8'h00;
            r_b_sr   <= 8'h00;
            r_res_sr <= 8'h00;
            r_bff    <= 1'b0;
            r_cnt    <= 3'd0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
        end else if (w_accept) begin
            r_a_sr   <= bus.a;
            r_b_sr   <= bus.b;
            r_bff    <= bus.borrowIn;
            r_cnt    <= 3'd0;
            r_a_msb  <= bus.a[7];
            r_b_msb  <= bus.b[7];
        end else if (w_shift) begin
            r_a_sr   <= {1'b0, r_a_sr[7:1]};
            r_b_sr   <= {1'b0, r_b_sr[7:1]};
            r_res_sr <= w_res_nxt;
            r_bff    <= w_bff_nxt;
            r_cnt    <= r_cnt + 3'd1;
        end
    end

    // Visible results only change on the edge that completes the 8th bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff       <= 8'h00;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (w_last) begin
            r_diff       <= w_res_nxt;
            r_borrow_out <= w_bff_nxt;
            r_overflow   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ready     = (r_state == S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.diff      = r_diff;
    assign bus.borrowOut = r_borrow_out;
    assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_sub_8_bit_serial.sv
// ============================================================================
//  Module      : tb_sub_8_bit_serial
//  Description : Self-checking bench for sub_8_bit_serial against an arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sub_8_bit_serial;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   n_done;
    int   n_acc;

    sub_8_bit_serial_if bus ();

    sub_8_bit_serial u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus.done) n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: 9-bit unsigned difference gives {borrowOut, diff}.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         output logic [7:0] d, output logic bo, output logic ov);
        logic [8:0] full;
        full = {1'b0, a} - {1'b0, b} - {8'd0, bin};
        d  = full[7:0];
        bo = full[8];
        ov = (a[7] != b[7]) && (d[7] != a[7]);
    endtask

    // Called at a negedge; returns at the negedge after the DONE cycle (ready=1).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input string tag);
        logic [7:0] ed;
        logic       ebo;
        logic       eov;
        int         lat;
        int         guard;
        guard = 0;
        while (!bus.ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_ready"}, {31'd0, bus.ready}, 32'd1);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.borrowIn = bin;
        @(negedge clk);
        n_acc++;
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.borrowIn = $urandom;
        chk({tag, "_busy"}, {31'd0, bus.ready}, 32'd0);
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        model(a, b, bin, ed, ebo, eov);
        chk({tag, "_lat"}, lat, 32'd8);
        chk({tag, "_diff"}, {24'd0, bus.diff}, {24'd0, ed});
        chk({tag, "_bo"}, {31'd0, bus.borrowOut}, {31'd0, ebo});
        chk({tag, "_ov"}, {31'd0, bus.overflow}, {31'd0, eov});
        @(negedge clk);
        chk({tag, "_pulse"}, {30'd0, bus.done, bus.ready}, 32'd1);
        chk({tag, "_hold"}, {24'd0, bus.diff}, {24'd0, ed});
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] ed;
        logic       ebo;
        logic       eov;
        int         seen;
        n_checks = 0; n_fail = 0; n_acc = 0;
        bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.borrowIn = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_outs", {21'd0, bus.done, bus.diff, bus.borrowOut, bus.overflow}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h05, 8'h03, 1'b0, "d1");
        run_op(8'h03, 8'h05, 1'b0, "d2");
        run_op(8'h00, 8'h00, 1'b1, "d3");
        run_op(8'h80, 8'h01, 1'b0, "d4");
        run_op(8'h7F, 8'hFF, 1'b0, "d5");
        run_op(8'hFF, 8'h00, 1'b1, "d6");

        // start held high with operands churning every cycle
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h01; bus.borrowIn = 1'b0;
        ra = 8'h00; rb = 8'h00;
        for (int n = 0; n <= 18; n++) begin
            @(negedge clk);
            if (n == 0 || n == 10) n_acc++;
            if (n == 9) begin
                chk("hold_rdy9", {31'd0, bus.ready}, 32'd1);
                ra = $urandom; rb = $urandom;
                bus.a = ra; bus.b = rb; bus.borrowIn = 1'b0;
            end else begin
                bus.a = $urandom; bus.b = $urandom; bus.borrowIn = $urandom;
            end
            if (n == 0 || n == 10) chk("hold_busy", {31'd0, bus.ready}, 32'd0);
            if (n == 8) begin
                chk("hold_done1", {31'd0, bus.done}, 32'd1);
                chk("hold_diff1", {24'd0, bus.diff}, 32'h0F);
            end
            if (n == 9) chk("hold_pulse", {31'd0, bus.done}, 32'd0);
            if (n == 18) begin
                model(ra, rb, 1'b0, ed, ebo, eov);
                chk("hold_done2", {31'd0, bus.done}, 32'd1);
                chk("hold_diff2", {24'd0, bus.diff}, {24'd0, ed});
            end
        end
        bus.start = 1'b0;
        @(negedge clk);

        // reset at E4 of an operation
        bus.start = 1'b1; bus.a = 8'hC3; bus.b = 8'h11; bus.borrowIn = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", {31'd0, bus.ready}, 32'd1);
        chk("abort_outs", {21'd0, bus.done, bus.diff, bus.borrowOut, bus.overflow}, 32'd0);
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        chk("abort_nodone", seen, 32'd0);

        // reset and start together: start dropped
        rst = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        chk("rst_start", {31'd0, bus.ready}, 32'd1);
        @(negedge clk);
        chk("rst_start2", {31'd0, bus.ready}, 32'd1);

        for (int i = 0; i < 2000; i++) begin
            run_op($urandom, $urandom, $urandom, "rnd");
        end

        repeat (3) @(negedge clk);
        chk("done_count", n_done, n_acc);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
